// File: rtl/btn_press_pkg.sv
// Shared types and helpers for the button press counter.
// Holds the debounce FSM state encoding and debounce length calculation.
package btn_press_pkg;

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } db_state_t;

  // Debounce length in clock cycles, never below one.
  function automatic int calc_db_cycles(
    input real t_s,
    input int  f_hz
  );
    int c;
    c = int'(t_s * real'(f_hz));
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Button debouncer: optional synchronizer, debounce FSM, rising-edge pulse.
// Macro BTN_SYNC_EN inserts a 2-flop synchronizer ahead of the FSM.
module debouncer
  import btn_press_pkg::*;
#(
  parameter int  CLK_FREQ = 100_000_000,
  parameter real DB_TIME  = 0.020
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic db,
  output logic press
);

  localparam int DB_CYCLES = calc_db_cycles(DB_TIME, CLK_FREQ);
  localparam int TW        = $clog2(DB_CYCLES + 1);
  localparam logic [TW-1:0] W_LAST = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] W_ONE  = TW'(1);

  logic          w_btn_s;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          r_db;
  logic          w_db_nxt;
  logic          r_db_q;

`ifdef BTN_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2;
`else
  assign w_btn_s = in;
`endif

  // FSM state, qualification timer and debounced level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOW;
      r_timer <= '0;
      r_db    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_db    <= w_db_nxt;
    end
  end

  // Next state: a level must hold for DB_CYCLES samples to be accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_db_nxt    = r_db;
    unique case (r_state)
      LOW: begin
        if (w_btn_s) begin
          w_state_nxt = WAIT_HIGH;
          w_timer_nxt = W_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!w_btn_s) begin
          w_state_nxt = LOW;
          w_timer_nxt = '0;
        end else if (r_timer >= W_LAST) begin
          w_state_nxt = HIGH;
          w_timer_nxt = '0;
          w_db_nxt    = 1'b1;
        end else begin
          w_timer_nxt = r_timer + W_ONE;
        end
      end
      HIGH: begin
        if (!w_btn_s) begin
          w_state_nxt = WAIT_LOW;
          w_timer_nxt = W_ONE;
        end
      end
      WAIT_LOW: begin
        if (w_btn_s) begin
          w_state_nxt = HIGH;
          w_timer_nxt = '0;
        end else if (r_timer >= W_LAST) begin
          w_state_nxt = LOW;
          w_timer_nxt = '0;
          w_db_nxt    = 1'b0;
        end else begin
          w_timer_nxt = r_timer + W_ONE;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_timer_nxt = '0;
        w_db_nxt    = 1'b0;
      end
    endcase
  end

  // Delayed level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_db_q <= 1'b0;
    end else begin
      r_db_q <= r_db;
    end
  end

  assign db    = r_db;
  assign press = r_db & ~r_db_q;

endmodule

// File: rtl/btn_press_counter.sv
// Debounced button press counter shown on a 4-bit LED bank.
// Build with BTN_SYNC_EN when btn comes straight from a board pin.
module btn_press_counter
  import btn_press_pkg::*;
#(
  parameter int  CLK_FREQ = 100_000_000,
  parameter real DB_TIME  = 0.020
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  output logic [3:0] led
);

  logic       w_db;
  logic       w_press;
  logic [3:0] r_led;

  debouncer #(
    .CLK_FREQ (CLK_FREQ),
    .DB_TIME  (DB_TIME)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .in    (btn),
    .db    (w_db),
    .press (w_press)
  );

  // Count presses; the 4-bit counter wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= 4'd0;
    end else if (w_press && w_db) begin
      r_led <= r_led + 4'd1;
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_btn_press_counter.sv
// Bench for btn_press_counter: scoreboard of expected LED changes.
// Honours BTN_SYNC_EN for the synchronizer latency.
module tb_btn_press_counter;

  localparam int DB = 500;
`ifdef BTN_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = DB + 1 + SYNC;

  typedef struct {
    logic [3:0] led;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn = 1'b0;
  logic [3:0] led;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [3:0] exp_led = 4'd0;
  logic [3:0] prev_led;
  logic mon_en = 1'b0;
  exp_t sb[$];

  btn_press_counter #(
    .CLK_FREQ (100_000_000),
    .DB_TIME  (5e-6)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .led   (led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every LED change must match the queue head, value and cycle.
  always @(negedge clk) begin
    if (mon_en && (led !== prev_led)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_led_change: led=%0d at cyc %0d, none expected",
                 led, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (led !== e.led || cyc !== e.cyc) begin
          errors++;
          $display("FAIL sb_led_change: led=%0d cyc=%0d, required led=%0d cyc=%0d",
                   led, cyc, e.led, e.cyc);
        end
      end
    end
    prev_led = led;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic bounce(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      btn = lvl;
      repeat (2) @(negedge clk);
      btn = ~lvl;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (led !== 4'd0) begin
      errors++;
      $display("FAIL reset_led: led=%0d, required 0", led);
    end
    checks++;
    if (u_dut.w_db !== 1'b0) begin
      errors++;
      $display("FAIL reset_db: db=%b, required 0", u_dut.w_db);
    end
    @(negedge clk);
    mon_en = 1'b1;
    repeat (1000) @(negedge clk);
    checks++;
    if (led !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold_led: led=%0d, required 0", led);
    end
  endtask

  task automatic test_bounce;
    bounce(1'b1, 10);
    repeat (600) @(negedge clk);
    checks++;
    if (led !== exp_led) begin
      errors++;
      $display("FAIL bounce_led: led=%0d, required %0d", led, exp_led);
    end
    checks++;
    if (u_dut.w_db !== 1'b0) begin
      errors++;
      $display("FAIL bounce_db: db=%b, required 0", u_dut.w_db);
    end
  endtask

  task automatic test_press_latency;
    int c0;
    bounce(1'b1, 5);
    btn = 1'b1;
    c0 = cyc;
    sb.push_back('{led: exp_led + 4'd1, cyc: c0 + LAT});
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (led !== exp_led) begin
      errors++;
      $display("FAIL latency_early: led=%0d, required %0d", led, exp_led);
    end
    @(negedge clk);
    exp_led = exp_led + 4'd1;
    checks++;
    if (led !== exp_led) begin
      errors++;
      $display("FAIL latency_on_time: led=%0d, required %0d", led, exp_led);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (u_dut.w_db !== 1'b1) begin
      errors++;
      $display("FAIL press_db: db=%b, required 1", u_dut.w_db);
    end
  endtask

  task automatic test_release;
    bounce(1'b0, 5);
    btn = 1'b0;
    repeat (600) @(negedge clk);
    checks++;
    if (u_dut.w_db !== 1'b0) begin
      errors++;
      $display("FAIL release_db: db=%b, required 0", u_dut.w_db);
    end
    checks++;
    if (led !== exp_led) begin
      errors++;
      $display("FAIL release_led: led=%0d, required %0d", led, exp_led);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 16; i++) begin
      btn = 1'b1;
      sb.push_back('{led: exp_led + 4'd1, cyc: cyc + LAT});
      repeat (600) @(negedge clk);
      exp_led = exp_led + 4'd1;
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL wrap_press%0d: led=%0d, required %0d", i, led, exp_led);
      end
      btn = 1'b0;
      repeat (600) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait;
    int c0;
    btn = 1'b1;
    repeat (SYNC + 1 + 300) @(negedge clk);
    reset = 1'b1;
    sb.push_back('{led: 4'd0, cyc: cyc + 1});
    @(negedge clk);
    reset = 1'b0;
    exp_led = 4'd0;
    checks++;
    if (led !== 4'd0) begin
      errors++;
      $display("FAIL midwait_reset_led: led=%0d, required 0", led);
    end
    c0 = cyc;
    sb.push_back('{led: 4'd1, cyc: c0 + LAT});
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (led !== 4'd0) begin
      errors++;
      $display("FAIL midwait_requalify_early: led=%0d, required 0", led);
    end
    @(negedge clk);
    exp_led = 4'd1;
    checks++;
    if (led !== exp_led) begin
      errors++;
      $display("FAIL midwait_requalify: led=%0d, required %0d", led, exp_led);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press_latency();
    test_release();
    test_wrap();
    test_reset_mid_wait();
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
